// File: rtl/sw_btn_ctrl.sv
// Stopwatch button front end: synchronises and debounces the start/stop and clear
// buttons, detects presses, and sequences the run/hold/clear levels for the counter.
module sw_btn_ctrl #(
  parameter int DEB_CYCLES = 4,
  parameter int CW         = 4,
  parameter int CLR_CYCLES = 2
) (
  input  logic ck,
  input  logic res,
  input  logic btn_ss,
  input  logic btn_clr,
  output logic start,
  output logic stop,
  output logic clr_n,
  output logic running
);

  // No valid/ready handshakes here: the buttons are free-running levels and
  // the outputs are levels/strobes that the downstream counter samples every cycle.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    HOLD  = 2'd2,
    CLEAR = 2'd3
  } state_t;

  localparam logic [CW-1:0] DEB_MAX  = CW'(DEB_CYCLES - 1);
  localparam logic [3:0]    CLR_LOAD = 4'(CLR_CYCLES - 1);

  // Bit 0 carries the start/stop button, bit 1 the clear button.
  logic [1:0]    btn;
  logic [1:0]    sync1;
  logic [1:0]    sync2;
  logic [1:0]    stable;
  logic [1:0]    stable_q;
  logic [1:0]    press;
  logic [CW-1:0] deb_cnt [2];

  state_t     state;
  state_t     state_nxt;
  logic [3:0] clr_cnt;
  logic [3:0] clr_cnt_nxt;

  assign btn = {btn_clr, btn_ss};

  always_ff @(posedge ck or negedge res) begin
    if (!res) begin
      sync1    <= '0;
      sync2    <= '0;
      stable   <= '0;
      stable_q <= '0;
      for (int i = 0; i < 2; i++) deb_cnt[i] <= '0;
    end else begin
      sync1    <= btn;
      sync2    <= sync1;
      stable_q <= stable;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] != stable[i]) begin
          if (deb_cnt[i] == DEB_MAX) begin
            stable[i]  <= sync2[i];
            deb_cnt[i] <= '0;
          end else begin
            deb_cnt[i] <= deb_cnt[i] + 1'b1;
          end
        end else begin
          deb_cnt[i] <= '0;
        end
      end
    end
  end

  assign press = stable & ~stable_q;

  always_ff @(posedge ck or negedge res) begin
    if (!res) begin
      state   <= IDLE;
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
    end
  end

  // Clear has priority when idle or holding; while running, start/stop wins.
  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    case (state)
      IDLE: begin
        if (press[1]) begin
          state_nxt   = CLEAR;
          clr_cnt_nxt = CLR_LOAD;
        end else if (press[0]) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (press[0]) state_nxt = HOLD;
      end
      HOLD: begin
        if (press[1]) begin
          state_nxt   = CLEAR;
          clr_cnt_nxt = CLR_LOAD;
        end else if (press[0]) begin
          state_nxt = RUN;
        end
      end
      CLEAR: begin
        if (clr_cnt == '0) state_nxt = IDLE;
        else               clr_cnt_nxt = clr_cnt - 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign start   = (state == RUN);
  assign stop    = (state == HOLD);
  assign clr_n   = (state != CLEAR);
  assign running = start;

endmodule

// File: doc/sw_btn_ctrl.md
# sw_btn_ctrl

Front-end control stage for the stopwatch. It turns two raw, bouncing push-buttons into the stopwatch's `start`/`stop` levels and its active-low clear strobe:

- **start/stop button:** a single toggle button.
- **clear button:** a separate button.

The block sits directly upstream of the stopwatch counter and drives its `start`, `stop` and `res` inputs. It contains a synchronizer and a debouncer per button, a press detector and a run/hold/clear state machine.

## Interface
Parameters:
- `DEB_CYCLES`, default 4: consecutive stable samples required to accept a button level change; legal range 2..2^CW-1.
- `CW`, default 4: width of each debounce counter.
- `CLR_CYCLES`, default 2: length of the `clr_n` low pulse in clock cycles; legal range 1..15.

Ports:
- `ck`: in, 1 bit. Single clock; all state updates on the rising edge.
- `res`: in, 1 bit. Asynchronous, active-low reset.
- `btn_ss`: in, 1 bit. Raw start/stop toggle button, active high, asynchronous to `ck`.
- `btn_clr`: in, 1 bit. Raw clear button, active high, asynchronous to `ck`.
- `start`: out, 1 bit. Level; 1 while the stopwatch must count.
- `stop`: out, 1 bit. Level; 1 while the stopwatch must hold its value.
- `clr_n`: out, 1 bit. Active-low clear strobe to the stopwatch `res` input.
- `running`: out, 1 bit. Status; equals `start`.

## Operation
**Synchronizer**
- Each button passes through 2 flops: `sync1` then `sync2`.

**Debouncer (one per button)**
- State: a `stable` register and a `CW`-bit counter.
- On each edge with `sync2 != stable`:
  - if the count equals `DEB_CYCLES-1`: `stable <= sync2`, count cleared;
  - otherwise the count increments.
- On any edge with `sync2 == stable`, the count clears.
- Result: a level change is accepted on the `DEB_CYCLES`-th consecutive differing sample. Any shorter excursion is discarded.

**Press detect**
- `press = stable & ~stable_q`, where `stable_q` is `stable` delayed by one cycle.
- Exactly one cycle per accepted rising edge. Releases produce nothing.

**FSM** (state registers drive the outputs directly)
- `IDLE`: start=0, stop=0, clr_n=1.
  - ss press → `RUN`.
  - clr press → `CLEAR`.
- `RUN`: start=1, stop=0.
  - ss press → `HOLD`.
  - clr press ignored.
- `HOLD`: start=0, stop=1.
  - ss press → `RUN`.
  - clr press → `CLEAR`.
- `CLEAR`: start=0, stop=0, clr_n=0.
  - Stays exactly `CLR_CYCLES` cycles (internal down-counter), then → `IDLE`.
  - All presses during `CLEAR` are discarded.

**Simultaneous presses**
- In `IDLE`/`HOLD`, clear wins.
- In `RUN`, ss wins (→ `HOLD`); the clear press is discarded.

**Encoding**
- `start` and `stop` are never both 1 in any state.

## Timing
**Reset (`res`=0)**, effective immediately and asynchronously:
- start=0, stop=0, clr_n=1, running=0.
- FSM in `IDLE`; all sync, stable, delay and counter registers cleared to 0.

**Reset mid-operation** (during debounce or `CLEAR`):
- Abandons the operation.
- A button still held when `res` returns high is seen as a fresh 0→1 change and is debounced normally, giving one press.

**Latency.** Raw button change first sampled at edge k:
- `sync2` valid after edge k+1.
- `stable` flips at edge k+1+`DEB_CYCLES`.
- `press` is high during the following cycle.
- FSM and outputs change at edge k+2+`DEB_CYCLES`: 6 edges with the default.

**Clear pulse**
- `clr_n` falls at the edge entering `CLEAR` and rises exactly `CLR_CYCLES` edges later, at the same edge that enters `IDLE`.

**Press spacing**
- Back-to-back presses need a release of at least `DEB_CYCLES` cycles plus a new hold of at least `DEB_CYCLES`.
- Holding a button indefinitely gives one press only.

**Counter width**
- The debounce counter never exceeds `DEB_CYCLES-1`, so no wrap occurs for legal parameters.

## Test plan
All scenarios use default parameters: `DEB_CYCLES`=4, `CLR_CYCLES`=2.

1. **Reset:** assert `res`=0 mid-cycle with random prior state → start=0, stop=0, clr_n=1, running=0 before the next `ck` edge. Hold low 2 cycles, release → outputs unchanged.
2. **Start:** from `IDLE`, raise `btn_ss` (first sampled at edge k) and hold 20 cycles → start=1, running=1 from edge k+6. Release → no change.
3. **Bounce rejection:** `btn_ss` pattern 1,1,1,0,1,1,1,0 (cycles) → `stable` never flips, outputs stay IDLE. Then a 3-cycle-low glitch on a held-high button → no release, no second press.
4. **Toggle:** three separated presses (6 high / 8 low) → RUN (1,0), then HOLD (0,1), then RUN (1,0), each 6 edges after the press's first sample.
5. **Clear:**
   - In `RUN`, press `btn_clr` → ignored, start stays 1.
   - In `HOLD`, press `btn_clr` → clr_n=0 for exactly 2 cycles, then start=0, stop=0.
   - Simultaneous ss+clr presses in `HOLD` → `CLEAR` taken; in `RUN` → `HOLD` taken.
6. **Reset mid-debounce:** hold `btn_ss`, pulse `res`=0 after 3 cycles while the button is still held → `IDLE`. After release of reset, exactly one press is recognized (start=1, 6 edges after the first post-reset sample).
